memory: RTL and testbench



---
 rtl/memory_pkg.sv | 17 +
 rtl/memory.sv | 72 +++++++
 tb/tb_memory.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// memory_pkg: shared constants and types for the riscy32 data memory.
//   DATA_WIDTH     - word width, fixed at 32 bits.
//   MEM_ADDR_WIDTH - default number of word-address bits (8192 words).
//   word_t         - one 32-bit memory word.
//   mem_depth()    - number of words for a given address width.
package memory_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned MEM_ADDR_WIDTH = 13;

  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic int unsigned mem_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/memory.sv
// memory: word-addressed 32-bit data memory for the riscy32 single-cycle core.
//
// Ports:
//   clk          - system clock, state changes on the rising edge.
//   rst_n        - asynchronous active-low reset; clears every word and blocks writes.
//   write_enable - store data_in at address on the rising edge of clk.
//   address      - word address; only address[ADDR_WIDTH-1:0] is used, so addresses wrap.
//   data_in      - write data (full word, no byte enables).
//   data_out     - read data for the word at address.
//
// Build option:
//   MEMORY_SYNC_READ_EN - when defined, data_out is registered (1-cycle read latency, a
//                         same-index read/write captures the old word). When undefined,
//                         data_out is a purely combinational read with no write bypass.
module memory
  import memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = memory_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int unsigned Depth = mem_depth(ADDR_WIDTH);

  word_t                  mem_q [Depth];
  logic [ADDR_WIDTH-1:0]  index;

  // Upper address bits are deliberately ignored: the memory aliases modulo its depth.
  assign index = address[ADDR_WIDTH-1:0];

  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:ADDR_WIDTH];

  // Storage. Every word is a resettable flop so the whole array clears asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_enable) begin
      mem_q[index] <= data_in;
    end
  end

`ifdef MEMORY_SYNC_READ_EN
  word_t rdata_d, rdata_q;

  // Sampled from the pre-edge array, so a same-index write returns the old word.
  always_comb begin
    rdata_d = mem_q[index];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign data_out = rdata_q;
`else
  assign data_out = mem_q[index];
`endif

endmodule

// File: tb/tb_memory.sv
// tb_memory: directed self-checking bench for the riscy32 data memory.
// Inputs change on the falling edge; outputs are sampled 1 time unit after a change
// (combinational read) or 1 time unit after the rising edge (registered read).
module tb_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_enable;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  memory #(
    .ADDR_WIDTH(13),
    .DATA_WIDTH(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_enable(write_enable),
    .address     (address),
    .data_in     (data_in),
    .data_out    (data_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address      = a;
    data_in      = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
`ifdef MEMORY_SYNC_READ_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    check(tag, data_out, exp);
  endtask

  initial begin
    rst_n        = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    data_in      = '0;

    // Reset held for two cycles; a write attempted meanwhile must be ignored.
    @(negedge clk);
    address      = 32'd9;
    data_in      = 32'hBAD0_0009;
    write_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", data_out, 32'h0);
    @(negedge clk);
    write_enable = 1'b0;
    rst_n        = 1'b1;

    rd("reset_rd0", 32'd0, 32'h0);
    rd("reset_rd1", 32'd1, 32'h0);
    rd("reset_rd4095", 32'd4095, 32'h0);
    rd("reset_blocked_wr", 32'd9, 32'h0);

    // Fill lower half with its own index.
    for (int i = 0; i < 4096; i++) begin
      wr(32'(i), 32'(i));
    end
    rd("fill_rd1", 32'd1, 32'd1);
    rd("fill_rd4095", 32'd4095, 32'd4095);
    rd("fill_rd1234", 32'd1234, 32'd1234);

    // Upper half is distinct storage at the default depth.
    wr(32'd4096, 32'hDEAD_BEEF);
    rd("high_rd4096", 32'd4096, 32'hDEAD_BEEF);
    rd("high_rd0", 32'd0, 32'h0);
    rd("high_rd4097", 32'd4097, 32'h0);

    // Wrapping modulo 8192 words.
    wr(32'd8192, 32'h1234_5678);
    rd("wrap_rd0", 32'd0, 32'h1234_5678);
    rd("wrap_rd8192", 32'd8192, 32'h1234_5678);
    rd("wrap_hi_rd3", 32'h8000_0003, 32'd3);
    wr(32'h8000_0003, 32'hCAFE_F00D);
    rd("wrap_hi_wr3", 32'd3, 32'hCAFE_F00D);

    // Multiple writes: i*2 to 0x10+i for i = 2..9.
    for (int i = 2; i <= 9; i++) begin
      wr(32'h10 + 32'(i), 32'(i * 2));
    end
    for (int i = 2; i <= 9; i++) begin
      rd($sformatf("multi_rd%0d", i), 32'h10 + 32'(i), 32'(i * 2));
    end

    // write_enable low must not store anything.
    @(negedge clk);
    address      = 32'h15;
    data_in      = 32'hFFFF_FFFF;
    write_enable = 1'b0;
    @(posedge clk);
    rd("we0_hold", 32'h15, 32'd10);

    // Same-address read and write at one edge: old word first, new word afterwards.
    @(negedge clk);
    address      = 32'h20;
    data_in      = 32'h1111_2222;
    write_enable = 1'b1;
`ifdef MEMORY_SYNC_READ_EN
    @(posedge clk);
    #1;
    check("rw_same_old", data_out, 32'h20);
    write_enable = 1'b0;
    @(posedge clk);
    #1;
    check("rw_same_new", data_out, 32'h1111_2222);
`else
    #1;
    check("rw_same_old", data_out, 32'h20);
    @(posedge clk);
    #1;
    check("rw_same_new", data_out, 32'h1111_2222);
    write_enable = 1'b0;
`endif

    // Mid-run asynchronous reset between clock edges.
    @(negedge clk);
    address = 32'd1;
    @(posedge clk);
    #2;
    check("pre_reset_rd1", data_out, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_out", data_out, 32'h0);
    address      = 32'd7;
    data_in      = 32'h0000_0077;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    rd("post_reset_rd1", 32'd1, 32'h0);
    rd("post_reset_rd7", 32'd7, 32'h0);
    rd("post_reset_rd4095", 32'd4095, 32'h0);
    rd("post_reset_rd4096", 32'd4096, 32'h0);
    rd("post_reset_rd0x15", 32'h15, 32'h0);
    rd("post_reset_rd0x20", 32'h20, 32'h0);

    // Memory still writable after reset.
    wr(32'd42, 32'h0BAD_F00D);
    rd("post_reset_wr42", 32'd42, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
